// File: rtl/id_stage_pkg.sv
// Shared widths, encodings and small helpers for the decode stage.
package id_stage_pkg;

  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int DS_TO_ES_BUS_WD = 136;
  localparam int BR_BUS_WD       = 34;
  localparam int WS_TO_RF_BUS_WD = 38;
  localparam int FWD_BUS_WD      = 39;

  localparam int ALU_OP_WD = 12;
  localparam int ALU_ADD   = 0;
  localparam int ALU_SUB   = 1;
  localparam int ALU_SLT   = 2;
  localparam int ALU_SLTU  = 3;
  localparam int ALU_AND   = 4;
  localparam int ALU_NOR   = 5;
  localparam int ALU_OR    = 6;
  localparam int ALU_XOR   = 7;
  localparam int ALU_SLL   = 8;
  localparam int ALU_SRL   = 9;
  localparam int ALU_SRA   = 10;
  localparam int ALU_LUI   = 11;

  localparam int OP_SPECIAL = 0;
  localparam int OP_JAL     = 3;
  localparam int OP_BEQ     = 4;
  localparam int OP_BNE     = 5;
  localparam int OP_ADDIU   = 9;
  localparam int OP_LUI     = 15;
  localparam int OP_LW      = 35;
  localparam int OP_SW      = 43;

  localparam int FN_SLL  = 0;
  localparam int FN_SRL  = 2;
  localparam int FN_SRA  = 3;
  localparam int FN_JR   = 8;
  localparam int FN_ADDU = 33;
  localparam int FN_SUBU = 35;
  localparam int FN_AND  = 36;
  localparam int FN_OR   = 37;
  localparam int FN_XOR  = 38;
  localparam int FN_NOR  = 39;
  localparam int FN_SLT  = 42;
  localparam int FN_SLTU = 43;

  typedef struct packed {
    logic        valid;
    logic        is_load;
    logic [4:0]  dest;
    logic [31:0] value;
  } fwd_bus_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_wr_t;

  function automatic logic [31:0] dec5(input logic [4:0] in);
    dec5 = 32'd1 << in;
  endfunction

  function automatic logic [63:0] dec6(input logic [5:0] in);
    dec6 = 64'd1 << in;
  endfunction

  // Youngest producer wins: EX, then MEM, then the WB write in flight, then the array.
  function automatic logic [31:0] bypass(input logic [4:0]  src,
                                         input logic [31:0] rf_val,
                                         input fwd_bus_t    es,
                                         input fwd_bus_t    ms,
                                         input rf_wr_t      ws);
    if (src == '0)                       return '0;
    if (es.valid && (es.dest == src))    return es.value;
    if (ms.valid && (ms.dest == src))    return ms.value;
    if (ws.we && (ws.waddr == src))      return ws.wdata;
    return rf_val;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two asynchronous reads, one synchronous write, r0 reads zero.
module id_stage_regfile
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic [4:0]  raddr1_i,
  output logic [31:0] rdata1_o,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] rf_q [32];
  logic [31:0] wsel;

  assign wsel = dec5(waddr_i);

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 32; i++) begin
      if (we_i && wsel[i[4:0]]) rf_q[i[4:0]] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : rf_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : rf_q[raddr2_i];

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID latch, decode, operand bypass, load-use stall and branch resolution.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_allowin,
  output logic                       ds_allowin,
  input  logic                       fs_to_ds_valid,
  input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       ds_to_es_valid,
  output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic [BR_BUS_WD-1:0]       br_bus,
  input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  input  logic [FWD_BUS_WD-1:0]      es_fwd_bus,
  input  logic [FWD_BUS_WD-1:0]      ms_fwd_bus
);

  logic                       ds_valid_q;
  logic [FS_TO_DS_BUS_WD-1:0] ds_bus_q;
  logic                       ds_ready_go;

  always_ff @(posedge clk) begin
    if (reset)           ds_valid_q <= 1'b0;
    else if (ds_allowin) ds_valid_q <= fs_to_ds_valid;
  end

  always_ff @(posedge clk) begin
    if (fs_to_ds_valid && ds_allowin) ds_bus_q <= fs_to_ds_bus;
  end

  assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid_q && ds_ready_go;

  logic [31:0] inst, pc;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] jidx;
  logic [63:0] op_d, fn_d;
  logic        unused_dec;

  assign inst = ds_bus_q[63:32];
  assign pc   = ds_bus_q[31:0];
  assign op   = inst[31:26];
  assign rs   = inst[25:21];
  assign rt   = inst[20:16];
  assign rd   = inst[15:11];
  assign func = inst[5:0];
  assign imm  = inst[15:0];
  assign jidx = inst[25:0];
  assign op_d = dec6(op);
  assign fn_d = dec6(func);
  assign unused_dec = ^{op_d, fn_d};

  logic is_r;
  logic i_addu, i_subu, i_slt, i_sltu, i_and, i_or, i_xor, i_nor;
  logic i_sll, i_srl, i_sra, i_jr;
  logic i_addiu, i_lui, i_lw, i_sw, i_beq, i_bne, i_jal;
  logic r_alu, rs_used, rt_used, is_br, gr_we;
  logic [ALU_OP_WD-1:0] alu_op;
  logic [4:0] dest;

  assign is_r    = op_d[OP_SPECIAL];
  assign i_addu  = is_r & fn_d[FN_ADDU];
  assign i_subu  = is_r & fn_d[FN_SUBU];
  assign i_slt   = is_r & fn_d[FN_SLT];
  assign i_sltu  = is_r & fn_d[FN_SLTU];
  assign i_and   = is_r & fn_d[FN_AND];
  assign i_or    = is_r & fn_d[FN_OR];
  assign i_xor   = is_r & fn_d[FN_XOR];
  assign i_nor   = is_r & fn_d[FN_NOR];
  assign i_sll   = is_r & fn_d[FN_SLL];
  assign i_srl   = is_r & fn_d[FN_SRL];
  assign i_sra   = is_r & fn_d[FN_SRA];
  assign i_jr    = is_r & fn_d[FN_JR];
  assign i_addiu = op_d[OP_ADDIU];
  assign i_lui   = op_d[OP_LUI];
  assign i_lw    = op_d[OP_LW];
  assign i_sw    = op_d[OP_SW];
  assign i_beq   = op_d[OP_BEQ];
  assign i_bne   = op_d[OP_BNE];
  assign i_jal   = op_d[OP_JAL];

  assign r_alu   = i_addu | i_subu | i_slt | i_sltu | i_and | i_or | i_xor | i_nor
                 | i_sll | i_srl | i_sra;
  assign rs_used = i_addu | i_subu | i_slt | i_sltu | i_and | i_or | i_xor | i_nor
                 | i_addiu | i_lw | i_sw | i_beq | i_bne | i_jr;
  assign rt_used = r_alu | i_sw | i_beq | i_bne;
  assign is_br   = i_beq | i_bne | i_jal | i_jr;
  assign gr_we   = r_alu | i_addiu | i_lui | i_lw | i_jal;

  always_comb begin
    alu_op           = '0;
    alu_op[ALU_ADD]  = i_addu | i_addiu | i_lw | i_sw | i_jal;
    alu_op[ALU_SUB]  = i_subu;
    alu_op[ALU_SLT]  = i_slt;
    alu_op[ALU_SLTU] = i_sltu;
    alu_op[ALU_AND]  = i_and;
    alu_op[ALU_NOR]  = i_nor;
    alu_op[ALU_OR]   = i_or;
    alu_op[ALU_XOR]  = i_xor;
    alu_op[ALU_SLL]  = i_sll;
    alu_op[ALU_SRL]  = i_srl;
    alu_op[ALU_SRA]  = i_sra;
    alu_op[ALU_LUI]  = i_lui;
  end

  always_comb begin
    dest = '0;
    if (r_alu)                         dest = rd;
    else if (i_addiu | i_lui | i_lw)   dest = rt;
    else if (i_jal)                    dest = 5'd31;
  end

  logic [31:0] rf_rdata1, rf_rdata2, rs_value, rt_value;
  fwd_bus_t    es_fwd, ms_fwd;
  rf_wr_t      ws_wr;

  assign es_fwd = es_fwd_bus;
  assign ms_fwd = ms_fwd_bus;
  assign ws_wr  = ws_to_rf_bus;

  id_stage_regfile u_regfile (
    .clk      (clk),
    .raddr1_i (rs),
    .rdata1_o (rf_rdata1),
    .raddr2_i (rt),
    .rdata2_o (rf_rdata2),
    .we_i     (ws_wr.we),
    .waddr_i  (ws_wr.waddr),
    .wdata_i  (ws_wr.wdata)
  );

  assign rs_value = bypass(rs, rf_rdata1, es_fwd, ms_fwd, ws_wr);
  assign rt_value = bypass(rt, rf_rdata2, es_fwd, ms_fwd, ws_wr);

  // Load data is not available until MEM, so a used source that matches a load in EX must wait.
  assign ds_ready_go = !(es_fwd.valid && es_fwd.is_load && (es_fwd.dest != '0) &&
                         ((rs_used && (es_fwd.dest == rs)) || (rt_used && (es_fwd.dest == rt))));

  logic        rs_eq_rt, br_taken, br_stall;
  logic [31:0] pc_p4, br_offs, br_target;

  assign rs_eq_rt = (rs_value == rt_value);
  assign pc_p4    = pc + 32'd4;
  assign br_offs  = {{14{imm[15]}}, imm, 2'b00};
  assign br_taken = ds_valid_q && ds_ready_go &&
                    ((i_beq && rs_eq_rt) || (i_bne && !rs_eq_rt) || i_jal || i_jr);
  assign br_stall = ds_valid_q && is_br && !ds_ready_go;

  always_comb begin
    br_target = '0;
    if (br_taken) begin
      if (i_beq | i_bne) br_target = pc_p4 + br_offs;
      else if (i_jal)    br_target = {pc_p4[31:28], jidx, 2'b00};
      else               br_target = rs_value;
    end
  end

  assign br_bus = {br_stall, br_taken, br_target};

  assign ds_to_es_bus = {alu_op, i_lw, (i_sll | i_srl | i_sra), i_jal,
                         (i_addiu | i_lui | i_lw | i_sw), i_jal, gr_we, i_sw,
                         dest, imm, rs_value, rt_value, pc};

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for the decode stage.
module tb_id_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         es_allowin;
  logic         ds_allowin;
  logic         fs_to_ds_valid;
  logic [63:0]  fs_to_ds_bus;
  logic         ds_to_es_valid;
  logic [135:0] ds_to_es_bus;
  logic [33:0]  br_bus;
  logic [37:0]  ws_to_rf_bus;
  logic [38:0]  es_fwd_bus;
  logic [38:0]  ms_fwd_bus;

  int passed = 0;
  int total  = 0;

  id_stage dut (
    .clk            (clk),
    .reset          (reset),
    .es_allowin     (es_allowin),
    .ds_allowin     (ds_allowin),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .br_bus         (br_bus),
    .ws_to_rf_bus   (ws_to_rf_bus),
    .es_fwd_bus     (es_fwd_bus),
    .ms_fwd_bus     (ms_fwd_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd;
    ws_to_rf_bus = '0;
    es_fwd_bus   = '0;
    ms_fwd_bus   = '0;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    fs_to_ds_bus   = {inst, pc};
    fs_to_ds_valid = 1'b1;
    step();
    fs_to_ds_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; es_allowin = 1'b1; fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0;
    clear_fwd();
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({ds_allowin, ds_to_es_valid, br_bus} !== {1'b1, 1'b0, 34'd0})
        $display("FAIL reset_hold cyc=%0d got allowin=%0b valid=%0b br=%h exp 1/0/0",
                 i, ds_allowin, ds_to_es_valid, br_bus);
      else passed++;
    end
    reset = 1'b0;
    step(); step();
    total++;
    if ({ds_to_es_valid, br_bus} !== 35'd0)
      $display("FAIL reset_idle got valid=%0b br=%h exp 0/0", ds_to_es_valid, br_bus);
    else passed++;
    // Preload $1 = 7 through the write port.
    ws_to_rf_bus = {1'b1, 5'd1, 32'd7};
    step();
    clear_fwd();
  endtask

  task automatic test_wb_bypass;
    issue(rtype(5'd2, 5'd2, 5'd3, 6'h21), 32'hbfc00000);
    ws_to_rf_bus = {1'b1, 5'd2, 32'd5};
    #1;
    total++;
    if ({ds_allowin, ds_to_es_valid} !== 2'b11)
      $display("FAIL wb_bypass_hs got allowin=%0b valid=%0b exp 1/1", ds_allowin, ds_to_es_valid);
    else passed++;
    total++;
    if ({ds_to_es_bus[95:64], ds_to_es_bus[63:32]} !== {32'd5, 32'd5})
      $display("FAIL wb_bypass_val got rs=%h rt=%h exp 5/5", ds_to_es_bus[95:64], ds_to_es_bus[63:32]);
    else passed++;
    total++;
    if ({ds_to_es_bus[135:124], ds_to_es_bus[118], ds_to_es_bus[116:112]} !== {12'h001, 1'b1, 5'd3})
      $display("FAIL addu_decode got alu=%h we=%0b dest=%0d exp 001/1/3",
               ds_to_es_bus[135:124], ds_to_es_bus[118], ds_to_es_bus[116:112]);
    else passed++;
    step();
    ws_to_rf_bus = '0;
    #1;
    total++;
    if (ds_to_es_valid !== 1'b0)
      $display("FAIL wb_bypass_drain got valid=%0b exp 0", ds_to_es_valid);
    else passed++;

    // addu $6,$0,$2: $0 ignores a dest-0 EX entry, $2 comes from the array.
    issue(rtype(5'd0, 5'd2, 5'd6, 6'h21), 32'hbfc00004);
    es_fwd_bus = {1'b1, 1'b0, 5'd0, 32'hdead};
    #1;
    total++;
    if ({ds_to_es_bus[95:64], ds_to_es_bus[63:32]} !== {32'd0, 32'd5})
      $display("FAIL r0_and_rf got rs=%h rt=%h exp 0/5", ds_to_es_bus[95:64], ds_to_es_bus[63:32]);
    else passed++;
    es_fwd_bus   = {1'b1, 1'b0, 5'd2, 32'haaaa};
    ms_fwd_bus   = {1'b1, 1'b0, 5'd2, 32'hbbbb};
    ws_to_rf_bus = {1'b1, 5'd2, 32'hcccc};
    #1;
    total++;
    if (ds_to_es_bus[63:32] !== 32'haaaa)
      $display("FAIL prio_ex got rt=%h exp aaaa", ds_to_es_bus[63:32]);
    else passed++;
    es_fwd_bus = '0;
    #1;
    total++;
    if (ds_to_es_bus[63:32] !== 32'hbbbb)
      $display("FAIL prio_mem got rt=%h exp bbbb", ds_to_es_bus[63:32]);
    else passed++;
    clear_fwd();
    step();
  endtask

  task automatic test_load_use;
    issue(rtype(5'd4, 5'd1, 5'd5, 6'h21), 32'hbfc00008);
    es_fwd_bus = {1'b1, 1'b1, 5'd4, 32'd0};
    #1;
    total++;
    if ({ds_allowin, ds_to_es_valid, br_bus[33]} !== 3'b000)
      $display("FAIL load_use_stall got allowin=%0b valid=%0b brstall=%0b exp 0/0/0",
               ds_allowin, ds_to_es_valid, br_bus[33]);
    else passed++;
    step();
    es_fwd_bus = '0;
    ms_fwd_bus = {1'b1, 1'b0, 5'd4, 32'h44};
    #1;
    total++;
    if ({ds_to_es_valid, ds_to_es_bus[95:64], ds_to_es_bus[63:32], ds_to_es_bus[31:0]} !==
        {1'b1, 32'h44, 32'd7, 32'hbfc00008})
      $display("FAIL load_use_issue got valid=%0b rs=%h rt=%h pc=%h exp 1/44/7/bfc00008",
               ds_to_es_valid, ds_to_es_bus[95:64], ds_to_es_bus[63:32], ds_to_es_bus[31:0]);
    else passed++;
    clear_fwd();
    step();

    // addiu $4,$1,1 does not read rt, so a load to $4 in EX must not stall it.
    issue(itype(6'd9, 5'd1, 5'd4, 16'd1), 32'hbfc0000c);
    es_fwd_bus = {1'b1, 1'b1, 5'd4, 32'd0};
    #1;
    total++;
    if ({ds_to_es_valid, ds_to_es_bus[95:64], ds_to_es_bus[111:96], ds_to_es_bus[120], ds_to_es_bus[116:112]} !==
        {1'b1, 32'd7, 16'd1, 1'b1, 5'd4})
      $display("FAIL addiu_no_stall got valid=%0b rs=%h imm=%h s2imm=%0b dest=%0d exp 1/7/1/1/4",
               ds_to_es_valid, ds_to_es_bus[95:64], ds_to_es_bus[111:96], ds_to_es_bus[120], ds_to_es_bus[116:112]);
    else passed++;
    clear_fwd();
    step();
  endtask

  task automatic test_branch;
    issue(itype(6'd4, 5'd1, 5'd1, 16'd3), 32'hbfc00010);
    #1;
    total++;
    if (br_bus !== {1'b0, 1'b1, 32'hbfc00020})
      $display("FAIL beq_taken got br=%h exp 1bfc00020", br_bus);
    else passed++;
    total++;
    if ({ds_to_es_valid, ds_to_es_bus[118], ds_to_es_bus[116:112]} !== {1'b1, 1'b0, 5'd0})
      $display("FAIL beq_decode got valid=%0b we=%0b dest=%0d exp 1/0/0",
               ds_to_es_valid, ds_to_es_bus[118], ds_to_es_bus[116:112]);
    else passed++;
    step();
    issue(itype(6'd5, 5'd1, 5'd1, 16'd3), 32'hbfc00010);
    #1;
    total++;
    if (br_bus[33:32] !== 2'b00)
      $display("FAIL bne_equal got stall/taken=%b exp 00", br_bus[33:32]);
    else passed++;
    step();
    issue(itype(6'd4, 5'd1, 5'd2, 16'd3), 32'hbfc00010);
    #1;
    total++;
    if (br_bus[33:32] !== 2'b00)
      $display("FAIL beq_unequal got stall/taken=%b exp 00", br_bus[33:32]);
    else passed++;
    step();
    issue(itype(6'd5, 5'd1, 5'd2, 16'hfffe), 32'hbfc00010);
    #1;
    total++;
    if (br_bus !== {1'b0, 1'b1, 32'hbfc0000c})
      $display("FAIL bne_back got br=%h exp 1bfc0000c", br_bus);
    else passed++;
    step();
    issue({6'd3, 26'h0100000}, 32'hbfc00010);
    #1;
    total++;
    if (br_bus !== {1'b0, 1'b1, 32'hb0400000})
      $display("FAIL jal_target got br=%h exp 1b0400000", br_bus);
    else passed++;
    total++;
    if ({ds_to_es_bus[121], ds_to_es_bus[119], ds_to_es_bus[118], ds_to_es_bus[116:112]} !==
        {1'b1, 1'b1, 1'b1, 5'd31})
      $display("FAIL jal_decode got pc1=%0b s8=%0b we=%0b dest=%0d exp 1/1/1/31",
               ds_to_es_bus[121], ds_to_es_bus[119], ds_to_es_bus[118], ds_to_es_bus[116:112]);
    else passed++;
    step();
  endtask

  task automatic test_jr_stall;
    issue(rtype(5'd31, 5'd0, 5'd0, 6'h08), 32'hbfc00020);
    es_fwd_bus = {1'b1, 1'b1, 5'd31, 32'd0};
    es_allowin = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({br_bus[33:32], ds_to_es_valid} !== 3'b100)
        $display("FAIL jr_stall cyc=%0d got stall/taken=%b valid=%0b exp 10/0",
                 i, br_bus[33:32], ds_to_es_valid);
      else passed++;
      step();
    end
    es_allowin = 1'b1;
    step();
    es_fwd_bus = '0;
    ms_fwd_bus = {1'b1, 1'b0, 5'd31, 32'h80001234};
    #1;
    total++;
    if ({ds_to_es_valid, br_bus} !== {1'b1, 1'b0, 1'b1, 32'h80001234})
      $display("FAIL jr_release got valid=%0b br=%h exp 1/180001234", ds_to_es_valid, br_bus);
    else passed++;
    clear_fwd();
    step();
  endtask

  task automatic test_back_to_back;
    logic [135:0] exp_bus;
    exp_bus = {12'h001, 7'b0000010, 5'd3, 16'h1821, 32'd5, 32'd5, 32'hbfc00040};
    es_allowin = 1'b0;
    issue(rtype(5'd2, 5'd2, 5'd3, 6'h21), 32'hbfc00040);
    fs_to_ds_bus   = {rtype(5'd1, 5'd1, 5'd7, 6'h21), 32'hbfc00044};
    fs_to_ds_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({ds_allowin, ds_to_es_valid} !== 2'b01)
        $display("FAIL hold_hs cyc=%0d got allowin=%0b valid=%0b exp 0/1", i, ds_allowin, ds_to_es_valid);
      else passed++;
      total++;
      if (ds_to_es_bus !== exp_bus)
        $display("FAIL hold_bus cyc=%0d got %h exp %h", i, ds_to_es_bus, exp_bus);
      else passed++;
      step();
    end
    es_allowin = 1'b1;
    step();
    fs_to_ds_valid = 1'b0;
    total++;
    if ({ds_to_es_valid, ds_to_es_bus[95:64], ds_to_es_bus[31:0]} !== {1'b1, 32'd7, 32'hbfc00044})
      $display("FAIL next_issue got valid=%0b rs=%h pc=%h exp 1/7/bfc00044",
               ds_to_es_valid, ds_to_es_bus[95:64], ds_to_es_bus[31:0]);
    else passed++;

    es_allowin = 1'b0;
    reset = 1'b1;
    step();
    total++;
    if (ds_to_es_valid !== 1'b0)
      $display("FAIL reset_mid_stall got valid=%0b exp 0", ds_to_es_valid);
    else passed++;
    reset = 1'b0;
    es_allowin = 1'b1;
    step();
    total++;
    if ({ds_to_es_valid, br_bus[33:32]} !== 3'b000)
      $display("FAIL after_reset got valid=%0b stall/taken=%b exp 0/00", ds_to_es_valid, br_bus[33:32]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_wb_bypass();
    test_load_use();
    test_branch();
    test_jr_stall();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
